// File: rtl/bist_pkg.sv
// Shared definitions for the BIST march controller and its datapath.
// Holds default widths, the march state encodings and the background helper.
package bist_pkg;

  localparam int BIST_ADDR_W = 8;
  localparam int BIST_DATA_W = 8;

  // March element encodings; the controller branches on these and the
  // datapath only needs them for debug visibility.
  typedef enum logic [2:0] {
    STANDBY    = 3'b001,
    WRITE_UP   = 3'b010,
    READ_DOWN  = 3'b011,
    WRITE_DOWN = 3'b100,
    READ_UP    = 3'b101
  } march_state_e;

  // Replicates the background bit across a default-width memory word.
  function automatic logic [BIST_DATA_W-1:0] exp_word(input logic data_bit);
    return {BIST_DATA_W{data_bit}};
  endfunction

endpackage

// File: rtl/bist_addr_cnt.sv
// Address counter for the memory under test, with terminal count c_out.
// Counts over 0..DEPTH-1 and wraps in both directions.
module bist_addr_cnt
  import bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              up_down,
  input  logic              rst_adr,
  input  logic              pr_res_adr,
  output logic [ADDR_W-1:0] addr,
  output logic              c_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Next address: rst_adr beats pr_res_adr beats counting; wrap is explicit
  // because DEPTH need not be a power of two.
  always_comb begin
    addr_d = addr_q;
    if (rst_adr) begin
      addr_d = '0;
    end else if (pr_res_adr) begin
      addr_d = LAST;
    end else if (enable) begin
      if (up_down) begin
        addr_d = (addr_q == LAST) ? '0 : addr_q + ADDR_W'(1);
      end else begin
        addr_d = (addr_q == '0) ? LAST : addr_q - ADDR_W'(1);
      end
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr  = addr_q;
  // Combinational so the controller can leave an element in the same cycle.
  assign c_out = enable & (up_down ? (addr_q == LAST) : (addr_q == '0));

endmodule

// File: rtl/bist_march_datapath.sv
// BIST march datapath: address counter, memory port, read-compare pipeline
// and optional fail log. Define BIST_FAIL_LOG_EN to add log_clr, fail_addr
// and fail_cnt.
module bist_march_datapath
  import bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DEPTH  = 256,
  parameter int DATA_W = BIST_DATA_W,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              up_down,
  input  logic              rst_adr,
  input  logic              pr_res_adr,
  input  logic              wr_en,
  input  logic              read_en,
  input  logic              data_bit,
  output logic              c_out,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BIST_FAIL_LOG_EN
  ,
  input  logic              log_clr,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [CNT_W-1:0]  fail_cnt
`endif
);

  logic [ADDR_W-1:0] addr;

  bist_addr_cnt #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .up_down   (up_down),
    .rst_adr   (rst_adr),
    .pr_res_adr(pr_res_adr),
    .addr      (addr),
    .c_out     (c_out)
  );

  assign mem_addr  = addr;
  assign mem_we    = wr_en;
  assign mem_re    = read_en;
  assign mem_wdata = {DATA_W{data_bit}};

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pv_d;
  logic [RD_LAT-1:0] pe_q;
  logic [RD_LAT-1:0] pe_d;
  logic              error_q;
  logic              error_d;
  logic              mis;

  // Shift the read request and its expected background along with the
  // memory latency so the compare lines up with the returned data.
  always_comb begin
    pv_d    = pv_q;
    pe_d    = pe_q;
    pv_d[0] = read_en;
    pe_d[0] = data_bit;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
  end

  // Compare at the last stage; the error pulse is registered for one cycle.
  always_comb begin
    mis     = pv_q[RD_LAT-1] & (mem_rdata != {DATA_W{pe_q[RD_LAT-1]}});
    error_d = mis;
  end

  // Compare pipeline and error registers; reset discards in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= '0;
      pe_q    <= '0;
      error_q <= 1'b0;
    end else begin
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

`ifdef BIST_FAIL_LOG_EN
  logic [RD_LAT-1:0][ADDR_W-1:0] pa_q;
  logic [RD_LAT-1:0][ADDR_W-1:0] pa_d;
  logic [ADDR_W-1:0]             fa_q;
  logic [ADDR_W-1:0]             fa_d;
  logic [CNT_W-1:0]              fc_q;
  logic [CNT_W-1:0]              fc_d;

  // Carry the read address down the pipeline so a failure can be located.
  always_comb begin
    pa_d    = pa_q;
    pa_d[0] = addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pa_d[i] = pa_q[i-1];
    end
  end

  // Fail log: clear wins, first failing address sticks, count saturates.
  always_comb begin
    fa_d = fa_q;
    fc_d = fc_q;
    if (log_clr) begin
      fa_d = '0;
      fc_d = '0;
    end else if (mis) begin
      if (fc_q == '0) begin
        fa_d = pa_q[RD_LAT-1];
      end
      if (fc_q != '1) begin
        fc_d = fc_q + CNT_W'(1);
      end
    end
  end

  // Fail log and address pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_q <= '0;
      fa_q <= '0;
      fc_q <= '0;
    end else begin
      pa_q <= pa_d;
      fa_q <= fa_d;
      fc_q <= fc_d;
    end
  end

  assign fail_addr = fa_q;
  assign fail_cnt  = fc_q;
`endif

endmodule
